// File: rtl/duck_flight_ctrl.sv
// duck_flight_ctrl: bird-side responder to the game control FSM. Spawns a duck on release,
// moves it once per frame with wall bounces, hit-tests trigger pulls and reports exactly one
// outcome (shot or flew away) per release.
//
// Ports:
//   CLK, RESET            system clock, synchronous active-low reset
//   frame_tick            one-cycle pulse per video frame; gates all motion and frame counting
//   release_bird          one-cycle spawn command, ignored while busy
//   shot, aim_x, aim_y    trigger pulse and crosshair position sampled with it
//   duck_x, duck_y        duck box top-left corner
//   duck_visible          duck is drawn
//   duck_state            0 idle, 1 fly, 2 hit pause, 3 fall, 4 escape
//   dx_right              horizontal direction, for sprite flip
//   bird_shot, flew_away  one-cycle outcome pulses
//   busy                  not idle
module duck_flight_ctrl #(
  parameter int unsigned SCREEN_W      = 640,
  parameter int unsigned SCREEN_H      = 480,
  parameter int unsigned DUCK_SIZE     = 32,
  parameter int unsigned GROUND_Y      = 400,
  parameter int unsigned FLY_SPEED     = 2,
  parameter int unsigned FALL_SPEED    = 4,
  parameter int unsigned ESC_SPEED     = 4,
  parameter int unsigned ESCAPE_FRAMES = 300,
  parameter int unsigned PAUSE_FRAMES  = 30
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       frame_tick,
  input  logic       release_bird,
  input  logic       shot,
  input  logic [9:0] aim_x,
  input  logic [9:0] aim_y,
  output logic [9:0] duck_x,
  output logic [9:0] duck_y,
  output logic       duck_visible,
  output logic [2:0] duck_state,
  output logic       dx_right,
  output logic       bird_shot,
  output logic       flew_away,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFly      = 3'd1,
    StHitPause = 3'd2,
    StFall     = 3'd3,
    StEscape   = 3'd4
  } state_e;

  localparam logic [9:0] XMax      = 10'(SCREEN_W - DUCK_SIZE);
  localparam logic [9:0] YMax      = 10'(GROUND_Y - DUCK_SIZE);
  localparam logic [9:0] ScreenW   = 10'(SCREEN_W);
  localparam logic [9:0] ScreenH   = 10'(SCREEN_H);
  localparam logic [9:0] DuckSize  = 10'(DUCK_SIZE);
  localparam logic [9:0] FlyStep   = 10'(FLY_SPEED);
  localparam logic [9:0] FallStep  = 10'(FALL_SPEED);
  localparam logic [9:0] EscStep   = 10'(ESC_SPEED);
  localparam logic [9:0] SpawnX    = 10'd64;
  localparam logic [8:0] EscLast   = 9'(ESCAPE_FRAMES - 1);
  localparam logic [8:0] PauseLast = 9'(PAUSE_FRAMES - 1);
  localparam logic [9:0] LfsrSeed  = 10'h2A5;

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       dx_q, dx_d;
  logic       up_q, up_d;
  logic [8:0] cnt_q, cnt_d;
  logic [9:0] lfsr_q, lfsr_d;
  logic       bird_shot_q, bird_shot_d;
  logic       flew_away_q, flew_away_d;

  logic       in_x, in_y, hit;

  // x^10 + x^7 + 1, maximal length, so a non-zero seed never reaches all-zero.
  assign lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

  // Box test on the registered position; 11-bit upper bound so x+SIZE cannot wrap.
  assign in_x = (aim_x >= x_q) && ({1'b0, aim_x} < ({1'b0, x_q} + {1'b0, DuckSize}));
  assign in_y = (aim_y >= y_q) && ({1'b0, aim_y} < ({1'b0, y_q} + {1'b0, DuckSize}));
  // An off-screen crosshair never scores.
  assign hit  = shot && (state_q == StFly) && in_x && in_y &&
                (aim_x < ScreenW) && (aim_y < ScreenH);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      dx_q        <= 1'b0;
      up_q        <= 1'b0;
      cnt_q       <= '0;
      lfsr_q      <= LfsrSeed;
      bird_shot_q <= 1'b0;
      flew_away_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      up_q        <= up_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      bird_shot_q <= bird_shot_d;
      flew_away_q <= flew_away_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    up_d        = up_q;
    cnt_d       = cnt_q;
    bird_shot_d = 1'b0;
    flew_away_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (release_bird) begin
          state_d = StFly;
          x_d     = SpawnX + {1'b0, lfsr_q[8:0]};
          y_d     = YMax;
          dx_d    = lfsr_q[9];
          up_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      StFly: begin
        // A hit freezes the duck and pre-empts both motion and the escape timeout.
        if (hit) begin
          state_d     = StHitPause;
          cnt_d       = '0;
          bird_shot_d = 1'b1;
        end else if (frame_tick) begin
          // Touching either side wall counts as a bounce.
          if (dx_q) begin
            if (({1'b0, x_q} + {1'b0, FlyStep}) >= {1'b0, XMax}) begin
              x_d  = XMax;
              dx_d = 1'b0;
            end else begin
              x_d = x_q + FlyStep;
            end
          end else begin
            if (x_q <= FlyStep) begin
              x_d  = '0;
              dx_d = 1'b1;
            end else begin
              x_d = x_q - FlyStep;
            end
          end
          if (up_q) begin
            if (y_q < FlyStep) begin
              y_d  = '0;
              up_d = 1'b0;
            end else begin
              y_d = y_q - FlyStep;
            end
          end else begin
            if (({1'b0, y_q} + {1'b0, FlyStep}) > {1'b0, YMax}) begin
              y_d  = YMax;
              up_d = 1'b1;
            end else begin
              y_d = y_q + FlyStep;
            end
          end
          if (cnt_q == EscLast) begin
            state_d = StEscape;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      StHitPause: begin
        if (frame_tick) begin
          if (cnt_q == PauseLast) begin
            state_d = StFall;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      StFall: begin
        if (frame_tick) begin
          if (({1'b0, y_q} + {1'b0, FallStep}) >= {1'b0, YMax}) begin
            y_d     = YMax;
            state_d = StIdle;
          end else begin
            y_d = y_q + FallStep;
          end
        end
      end
      StEscape: begin
        if (frame_tick) begin
          if (y_q < EscStep) begin
            y_d         = '0;
            state_d     = StIdle;
            flew_away_d = 1'b1;
          end else begin
            y_d = y_q - EscStep;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    duck_x       = x_q;
    duck_y       = y_q;
    dx_right     = dx_q;
    duck_state   = state_q;
    busy         = (state_q != StIdle);
    duck_visible = (state_q != StIdle);
    bird_shot    = bird_shot_q;
    flew_away    = flew_away_q;
  end

endmodule

// File: tb/tb_duck_flight_ctrl.sv
module tb_duck_flight_ctrl;

  logic       CLK = 1'b0;
  logic       RESET, frame_tick, release_bird, shot;
  logic [9:0] aim_x, aim_y;
  logic [9:0] duck_x, duck_y;
  logic       duck_visible, dx_right, bird_shot, flew_away, busy;
  logic [2:0] duck_state;

  always #5 CLK = ~CLK;

  duck_flight_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .frame_tick   (frame_tick),
    .release_bird (release_bird),
    .shot         (shot),
    .aim_x        (aim_x),
    .aim_y        (aim_y),
    .duck_x       (duck_x),
    .duck_y       (duck_y),
    .duck_visible (duck_visible),
    .duck_state   (duck_state),
    .dx_right     (dx_right),
    .bird_shot    (bird_shot),
    .flew_away    (flew_away),
    .busy         (busy)
  );

  typedef struct packed {
    int         chk;
    logic [2:0] st;
    logic [9:0] x;
    logic [9:0] y;
    logic       dx;
    logic       use_y;
  } exp_t;

  exp_t  eq[$];
  string nq[$];
  int    pkind[$];
  int    pchk[$];

  int cyc     = 0;
  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  int         ms, mx, my, mcnt;
  bit         mdx, mup;
  logic [9:0] ml;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Monitor: pops scheduled expectations and outcome pulses as the DUT presents them.
  initial forever begin
    exp_t  e;
    string nm;
    bit    ok;
    int    k;
    @(negedge CLK);
    while (eq.size() > 0 && eq[0].chk <= cyc) begin
      e  = eq.pop_front();
      nm = nq.pop_front();
      n_total++;
      ok = (duck_state === e.st) && (duck_x === e.x) && (dx_right === e.dx) &&
           (!e.use_y || duck_y === e.y) &&
           (duck_visible === (e.st != 3'd0)) && (busy === (e.st != 3'd0));
      if (ok) n_pass++;
      else $display("FAIL %s cyc %0d: got st=%0d x=%0d y=%0d dx=%0b vis=%0b busy=%0b, want st=%0d x=%0d y=%0d(%0s) dx=%0b",
                    nm, cyc, duck_state, duck_x, duck_y, dx_right, duck_visible, busy,
                    e.st, e.x, e.y, e.use_y ? "chk" : "any", e.dx);
    end
    if (bird_shot === 1'b1 || flew_away === 1'b1) begin
      n_total++;
      if (pkind.size() == 0) begin
        $display("FAIL unexpected_pulse cyc %0d: got bird_shot=%0b flew_away=%0b, want none",
                 cyc, bird_shot, flew_away);
      end else begin
        k = pkind.pop_front();
        ok = !(bird_shot && flew_away) && (pchk.pop_front() == cyc) &&
             ((k == 0) ? bird_shot : flew_away);
        if (ok) n_pass++;
        else $display("FAIL pulse cyc %0d: got bird_shot=%0b flew_away=%0b, want %s",
                      cyc, bird_shot, flew_away, (k == 0) ? "bird_shot" : "flew_away");
      end
    end
  end

  task automatic model_cycle(input bit rst_n, input bit tick, input bit rel, input bit sh,
                             input int ax, input int ay, output bit p_shot, output bit p_away);
    logic [9:0] nl;
    p_shot = 1'b0;
    p_away = 1'b0;
    nl = (ml << 1) | 10'(ml[9] ^ ml[6]);
    if (!rst_n) begin
      ms = 0; mx = 0; my = 0; mdx = 0; mup = 0; mcnt = 0; ml = 10'h2A5;
      return;
    end
    case (ms)
      0: if (rel) begin
        mx = 64 + int'(ml[8:0]); my = 368; mdx = ml[9]; mup = 1; mcnt = 0; ms = 1;
      end
      1: begin
        if (sh && ax >= mx && ax < mx + 32 && ay >= my && ay < my + 32) begin
          ms = 2; mcnt = 0; p_shot = 1;
        end else if (tick) begin
          if (mdx) begin
            if (mx + 2 + 32 >= 640) begin mx = 608; mdx = 0; end else mx += 2;
          end else begin
            if (mx - 2 <= 0) begin mx = 0; mdx = 1; end else mx -= 2;
          end
          if (mup) begin
            if (my - 2 < 0) begin my = 0; mup = 0; end else my -= 2;
          end else begin
            if (my + 2 > 368) begin my = 368; mup = 1; end else my += 2;
          end
          if (mcnt == 299) begin ms = 4; mcnt = 0; end else mcnt++;
        end
      end
      2: if (tick) begin
        if (mcnt == 29) begin ms = 3; mcnt = 0; end else mcnt++;
      end
      3: if (tick) begin
        if (my + 4 >= 368) begin my = 368; ms = 0; end else my += 4;
      end
      4: if (tick) begin
        if (my < 4) begin my = 0; ms = 0; p_away = 1; end else my -= 4;
      end
      default: ms = 0;
    endcase
    ml = nl;
  endtask

  task automatic step(input bit rst_n, input bit tick, input bit rel, input bit sh,
                      input int ax, input int ay);
    bit   ps, pa;
    exp_t e;
    @(negedge CLK);
    RESET        = rst_n;
    frame_tick   = tick;
    release_bird = rel;
    shot         = sh;
    aim_x        = 10'(ax);
    aim_y        = 10'(ay);
    model_cycle(rst_n, tick, rel, sh, ax, ay, ps, pa);
    e.chk = cyc + 1; e.st = 3'(ms); e.x = 10'(mx); e.y = 10'(my); e.dx = mdx; e.use_y = 1'b1;
    eq.push_back(e);
    nq.push_back("model");
    if (ps) begin pkind.push_back(0); pchk.push_back(cyc + 1); end
    if (pa) begin pkind.push_back(1); pchk.push_back(cyc + 1); end
  endtask

  // Hand-computed expectation for the cycle just driven by step().
  task automatic hand(input string nm, input int st, input int x, input int y, input bit dx,
                      input bit use_y);
    exp_t e;
    e.chk = cyc + 1; e.st = 3'(st); e.x = 10'(x); e.y = 10'(y); e.dx = dx; e.use_y = use_y;
    eq.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    RESET = 1'b0; frame_tick = 1'b0; release_bird = 1'b0; shot = 1'b0;
    aim_x = '0; aim_y = '0;

    // Reset, and reset wins over a concurrent release.
    repeat (3) step(0, 0, 0, 0, 0, 0);
    hand("reset", 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0);
    hand("reset_beats_release", 0, 0, 0, 0, 1);

    // Flight 1: spawn from seed, busy release ignored, edge misses, corner hit, pause, fall.
    step(1, 0, 1, 0, 0, 0);       hand("spawn", 1, 229, 368, 1, 1);
    step(1, 0, 1, 0, 0, 0);       hand("release_while_busy", 1, 229, 368, 1, 1);
    step(1, 0, 0, 1, 261, 380);   hand("miss_x_exclusive", 1, 229, 368, 1, 1);
    step(1, 0, 0, 1, 240, 400);   hand("miss_y_exclusive", 1, 229, 368, 1, 1);
    step(1, 0, 0, 1, 228, 380);   hand("miss_left", 1, 229, 368, 1, 1);
    step(1, 0, 0, 1, 229, 368);   hand("hit_corner", 2, 229, 368, 1, 1);
    ticks(29);                    hand("pause_29", 2, 229, 368, 1, 1);
    ticks(1);                     hand("pause_to_fall", 3, 229, 368, 1, 1);
    ticks(1);                     hand("fall_lands", 0, 229, 368, 1, 1);
    step(1, 0, 0, 1, 229, 368);   hand("idle_ignores_shot", 0, 229, 368, 1, 1);

    // Flight 2: top bounce, right wall bounce, escape and climb-out.
    repeat (2) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);       hand("spawn2", 1, 229, 368, 1, 1);
    ticks(189);                   hand("fly_189", 1, 607, 8, 1, 1);
    step(1, 0, 0, 0, 0, 0);       hand("no_tick_no_motion", 1, 607, 8, 1, 1);
    ticks(1);                     hand("right_wall", 1, 608, 10, 0, 1);
    ticks(1);                     hand("right_rebound", 1, 606, 12, 0, 1);
    ticks(108);                   hand("fly_299", 1, 390, 228, 0, 1);
    ticks(1);                     hand("escape_entry", 4, 388, 230, 0, 1);
    step(1, 0, 1, 1, 390, 240);   hand("escape_ignores", 4, 388, 230, 0, 1);
    ticks(1);                     hand("escape_step", 4, 388, 226, 0, 1);
    ticks(56);                    hand("escape_y2", 4, 388, 2, 0, 1);
    ticks(1);                     hand("escaped", 0, 388, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);       hand("after_escape", 0, 388, 0, 0, 1);

    // Flight 3: hit in the escape-timeout cycle, then reset mid-fall.
    repeat (2) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);       hand("spawn3", 1, 229, 368, 1, 1);
    ticks(299);                   hand("fly_299b", 1, 390, 228, 0, 1);
    step(1, 1, 0, 1, 395, 235);   hand("hit_beats_escape", 2, 390, 228, 0, 1);
    step(1, 0, 0, 0, 0, 0);       hand("pause_hold", 2, 390, 228, 0, 1);
    ticks(30);                    hand("fall3", 3, 390, 228, 0, 1);
    ticks(3);                     hand("falling", 3, 390, 240, 0, 1);
    step(0, 1, 0, 0, 0, 0);       hand("reset_mid_fall", 0, 0, 0, 0, 1);

    // Flight 4: left-moving duck with odd x reaches x=1, then bounces off the left wall.
    step(1, 0, 0, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      if (ml[9] == 1'b0 && ml[0] == 1'b1) found = 1'b1;
      else step(1, 0, 0, 0, 0, 0);
    end
    n_total++;
    if (found) n_pass++;
    else $display("FAIL lfsr_search: got no left-moving odd spawn, want one within 1100 cycles");
    if (found) begin
      step(1, 0, 1, 0, 0, 0);
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
        if (mx == 1) found = 1'b1;
        else ticks(1);
      end
      n_total++;
      if (found) n_pass++;
      else $display("FAIL reach_x1: got x=%0d after 400 ticks, want 1", mx);
      ticks(1);                   hand("left_wall", 1, 0, 0, 1, 0);
      ticks(1);                   hand("left_rebound", 1, 2, 0, 1, 0);
    end

    repeat (2) step(1, 0, 0, 0, 0, 0);
    repeat (3) @(negedge CLK);

    n_total++;
    if (eq.size() == 0) n_pass++;
    else $display("FAIL drain_expectations: got %0d pending, want 0", eq.size());
    n_total++;
    if (pkind.size() == 0) n_pass++;
    else $display("FAIL missing_pulse: got %0d expected pulses never seen, want 0", pkind.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
